// File: rtl/bw_seq_multiplier.sv
// Iterative signed multiplier: one Baugh-Wooley partial-product row is accumulated per clock,
// and the 2*WIDTH-bit product is presented WIDTH cycles after an accepted start.
module bw_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      start_in,
    input  logic signed [WIDTH-1:0]   a_in,
    input  logic signed [WIDTH-1:0]   b_in,
    output logic                      busy_out,
    output logic                      done_out,
    output logic signed [2*WIDTH-1:0] p_out
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    // The two constant 1s of the Baugh-Wooley correction are folded into the accumulator at start
    localparam logic [PW-1:0] BW_CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                    state;
    logic signed [WIDTH-1:0]   a_q;
    logic signed [WIDTH-1:0]   b_q;
    logic        [CW-1:0]      cnt;
    logic        [PW-1:0]      acc;
    logic        [PW-1:0]      acc_next;
    logic                      last_row;

    // Unshifted modified row: sign-position term inverted on ordinary rows, magnitude terms on the last
    function automatic logic [PW-1:0] bw_row(input logic [WIDTH-1:0] a,
                                             input logic             b_bit,
                                             input logic             last);
        logic [WIDTH-1:0] r;
        r = a & {WIDTH{b_bit}};
        if (last)
            r[WIDTH-2:0] = ~r[WIDTH-2:0];
        else
            r[WIDTH-1] = ~r[WIDTH-1];
        return {{WIDTH{1'b0}}, r};
    endfunction

    assign last_row = (cnt == CW'(WIDTH - 1));

    always_comb begin
        acc_next = acc + (bw_row(a_q, b_q[cnt], last_row) << cnt);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            busy_out <= 1'b0;
            done_out <= 1'b0;
            p_out    <= '0;
            cnt      <= '0;
            acc      <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_in) begin
                        a_q      <= a_in;
                        b_q      <= b_in;
                        cnt      <= '0;
                        acc      <= BW_CORR;
                        busy_out <= 1'b1;
                        state    <= CALC;
                    end else begin
                        state    <= IDLE;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (last_row) begin
                        p_out    <= acc_next;
                        done_out <= 1'b1;
                        busy_out <= 1'b0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bw_seq_multiplier.sv
// Directed checks of bw_seq_multiplier at WIDTH=8 plus an exhaustive sweep at WIDTH=4.
module tb_bw_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst8_n, start8, busy8, done8;
    logic signed [7:0]  a8, b8;
    logic signed [15:0] p8;

    logic               rst4_n, start4, busy4, done4;
    logic signed [3:0]  a4, b4;
    logic signed [7:0]  p4;

    bw_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk_in(clk), .rst_n_in(rst8_n), .start_in(start8),
        .a_in(a8), .b_in(b8), .busy_out(busy8), .done_out(done8), .p_out(p8)
    );

    bw_seq_multiplier #(.WIDTH(4)) dut4 (
        .clk_in(clk), .rst_n_in(rst4_n), .start_in(start4),
        .a_in(a4), .b_in(b4), .busy_out(busy4), .done_out(done4), .p_out(p4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Start a WIDTH=8 multiply; returns edges from accepting edge to done, and busy cycle count
    task automatic mul8(input logic signed [7:0] a, input logic signed [7:0] b,
                        output int lat, output int bcnt);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = -1; bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done8) begin
                lat = k - 1;
                break;
            end
            if (busy8) bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic mul4(input logic signed [3:0] a, input logic signed [3:0] b, output int lat);
        @(negedge clk);
        a4 = a; b4 = b; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (done4) begin
                lat = k - 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int lat, bcnt, ndone, dk, gap;
        logic [15:0] pd;

        rst8_n = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0;
        rst4_n = 1'b0; start4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_done", 64'(done8), 64'd0);
        chk("rst_p",    64'($unsigned(p8)), 64'h0);
        rst8_n = 1'b1; rst4_n = 1'b1;

        // Most negative squared
        mul8(-8'sd128, -8'sd128, lat, bcnt);
        chk("m128_lat",  64'(lat),  64'd8);
        chk("m128_busy", 64'(bcnt), 64'd8);
        chk("m128_p",    64'($unsigned(p8)), 64'h4000);
        chk("m128_excl", 64'(busy8), 64'd0);

        mul8(-8'sd1, 8'sd1, lat, bcnt);
        chk("neg1_p", 64'($unsigned(p8)), 64'hFFFF);
        mul8(8'sd127, -8'sd128, lat, bcnt);
        chk("maxmin_p", 64'($unsigned(p8)), 64'hC080);
        mul8(8'sd0, -8'sd77, lat, bcnt);
        chk("zero_p", 64'($unsigned(p8)), 64'h0000);
        chk("zero_lat", 64'(lat), 64'd8);

        // Start during CALC is ignored
        @(negedge clk);
        a8 = 8'sd3; b8 = 8'sd5; start8 = 1'b1;
        @(negedge clk);
        ndone = 0; dk = -1; pd = '0;
        for (int k = 1; k <= 24; k++) begin
            if (done8) begin
                ndone++;
                dk = k - 1;
                pd = p8;
            end
            start8 = (k == 3);
            if (k == 3) begin
                a8 = 8'sd9; b8 = 8'sd9;
            end
            @(negedge clk);
        end
        chk("ign_ndone", 64'(ndone), 64'd1);
        chk("ign_lat",   64'(dk),    64'd8);
        chk("ign_p",     64'(pd),    64'd15);

        // Back-to-back
        mul8(8'sd6, 8'sd7, lat, bcnt);
        chk("b2b_p1", 64'($unsigned(p8)), 64'd42);
        a8 = -8'sd2; b8 = -8'sd3; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("b2b_busy", 64'(busy8), 64'd1);
        chk("b2b_done1cyc", 64'(done8), 64'd0);
        gap = -1;
        for (int j = 1; j <= 30; j++) begin
            if (done8) begin
                gap = j;
                break;
            end
            if (j == 4) chk("b2b_hold", 64'($unsigned(p8)), 64'd42);
            @(negedge clk);
        end
        chk("b2b_gap", 64'(gap), 64'd9);
        chk("b2b_p2",  64'($unsigned(p8)), 64'd6);

        // Asynchronous abort mid-operation
        @(negedge clk);
        a8 = 8'sd12; b8 = 8'sd12; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst8_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy8), 64'd0);
        chk("abort_done", 64'(done8), 64'd0);
        chk("abort_p",    64'($unsigned(p8)), 64'h0);
        @(negedge clk);
        rst8_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            if (done8) ndone++;
            @(negedge clk);
        end
        chk("abort_nodone", 64'(ndone), 64'd0);
        chk("abort_p_hold", 64'($unsigned(p8)), 64'h0);

        // Exhaustive WIDTH=4
        for (int ai = -8; ai < 8; ai++) begin
            for (int bi = -8; bi < 8; bi++) begin
                logic [7:0] exp4;
                exp4 = 8'(ai * bi);
                mul4(4'(ai), 4'(bi), lat);
                chk($sformatf("w4_p %0d*%0d", ai, bi), 64'($unsigned(p4)), 64'(exp4));
                chk($sformatf("w4_lat %0d*%0d", ai, bi), 64'(lat), 64'd4);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bw_seq_multiplier.md
# bw_seq_multiplier

Parametrised, iterative signed two's-complement multiplier using the Baugh-Wooley partial-product formulation. It adds one modified partial-product row per clock and presents the 2·WIDTH-bit product after WIDTH cycles, using a start/busy/done handshake. It is the sequential successor to the combinational full-adder cell in the Baugh-Wooley multiplier tree. It trades the full array for one row adder plus an accumulator.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- start_in  input  1  request a multiply; sampled only in IDLE or DONE.
- a_in  input  WIDTH  multiplicand, signed two's complement; captured on an accepted start.
- b_in  input  WIDTH  multiplier, signed two's complement; captured on an accepted start.
- busy_out  output  1  high while in CALC.
- done_out  output  1  one-cycle pulse; p_out is valid from this cycle.
- p_out  output  2·WIDTH  signed product; holds until the next completion.

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE.
- Transitions:
  - IDLE: start_in=1 → CALC; otherwise stay in IDLE.
  - CALC: row counter = WIDTH−1 → DONE; otherwise stay and increment the counter.
  - DONE: start_in=1 → CALC, giving back-to-back operation; otherwise → IDLE.
- On an accepted start:
  - a_in and b_in are latched into internal A and B.
  - Row counter i is set to 0.
  - The accumulator is loaded with the Baugh-Wooley correction constant 2^WIDTH + 2^(2·WIDTH−1).
- Each CALC cycle adds row i, shifted left by i, to the accumulator.
  - Rows i < WIDTH−1:
    - bits j < WIDTH−1 are A[j]&B[i];
    - bit WIDTH−1 is ~(A[WIDTH−1]&B[i]).
  - Row i = WIDTH−1:
    - bits j < WIDTH−1 are ~(A[j]&B[WIDTH−1]);
    - bit WIDTH−1 is A[WIDTH−1]&B[WIDTH−1].
- Arithmetic is modulo 2^(2·WIDTH). Carries out of bit 2·WIDTH−1 are discarded, and no overflow is possible.
- On the CALC→DONE transition, p_out is loaded with the final accumulator value. p_out never shows intermediate sums.
- start_in is ignored during CALC. No queuing, no error flag.
- a_in and b_in may change freely after the start edge, since the latched copies are used.

## Timing
- Reset values: state IDLE, busy_out 0, done_out 0, p_out 0, counter 0, accumulator 0.
- Reset asserted mid-operation aborts immediately to the reset values. The result is lost, and no done_out is produced.
- Start accepted at rising edge E0:
  - busy_out = 1 in cycles E0..E(WIDTH−1);
  - done_out = 1 and p_out valid in the cycle following edge E(WIDTH);
  - latency = WIDTH cycles from the accepting edge.
- Back-to-back: start_in high during the DONE cycle is accepted at edge E(WIDTH+1).
  - busy_out rises with no idle gap.
  - p_out keeps the previous product until the new completion.
- Throughput: one product per WIDTH+1 cycles when back-to-back.
- done_out is registered and is never high for more than one consecutive cycle.
- busy_out and done_out are never high together.

## Test plan
- WIDTH=8, a=−128, b=−128 → done_out exactly 8 cycles after the start edge; p_out=0x4000 (16384); busy_out high for 8 cycles.
- WIDTH=8 products, each checked against a behavioural signed multiply:
  - a=−1, b=1 → p_out=0xFFFF;
  - a=127, b=−128 → p_out=0xC080 (−16256);
  - a=0, b=−77 → p_out=0x0000.
- WIDTH=8, start a=3, b=5; pulse start_in with a=9, b=9 during CALC cycle 3 → exactly one done_out, with p_out=15.
- WIDTH=8 back-to-back:
  - start 6×7, then hold start_in high in the DONE cycle with a=−2, b=−3;
  - required: p_out=42 at the first done_out;
  - busy_out high again in the very next cycle;
  - p_out=6 at the second done_out, 9 cycles after the first.
- WIDTH=8, 12×12 started; deassert rst_n_in in CALC cycle 4 → all outputs 0 asynchronously; no done_out afterwards.
- WIDTH=4, exhaustive: all 256 signed operand pairs → every p_out equals a·b mod 256; latency 4 cycles each.
